mbinit_substate_controller: RTL and testbench

Sequences the MBINIT sub-states CAL -> REPAIRCLK -> REPAIRVAL -> REVERSALMB -> REPAIRMB. It enables one sub-state wrapper at a time and advances on that wrapper's end flag. It owns the single sideband TX channel: only the active wrapper's message is forwarded. It also enforces a per-sub-state timeout and collects train-error requests for the LTSM.

---
 rtl/mbinit_substate_controller_if.sv | 30 +++
 rtl/mbinit_substate_controller.sv | 122 ++++++++++++
 tb/tb_mbinit_substate_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mbinit_substate_controller_if.sv
// Handshake bundle between the MBINIT sub-state controller, the LTSM,
// the five sub-state wrappers and the sideband TX channel.
interface mbinit_substate_controller_if;
  logic        i_MBINIT_start;
  logic [4:0]  i_sub_end;
  logic [4:0]  i_sub_error;
  logic [4:0]  i_sub_tx_valid;
  logic [19:0] i_sub_tx_msg;
  logic        i_falling_edge_busy;
  logic [4:0]  o_sub_en;
  logic [3:0]  o_TX_SbMessage;
  logic        o_ValidOutDatat;
  logic        o_MBINIT_end;
  logic        o_train_error_req;
  logic [2:0]  o_state;

  modport master (
    input  i_MBINIT_start, i_sub_end, i_sub_error, i_sub_tx_valid, i_sub_tx_msg,
           i_falling_edge_busy,
    output o_sub_en, o_TX_SbMessage, o_ValidOutDatat, o_MBINIT_end,
           o_train_error_req, o_state
  );

  modport slave (
    output i_MBINIT_start, i_sub_end, i_sub_error, i_sub_tx_valid, i_sub_tx_msg,
           i_falling_edge_busy,
    input  o_sub_en, o_TX_SbMessage, o_ValidOutDatat, o_MBINIT_end,
           o_train_error_req, o_state
  );
endinterface

// File: rtl/mbinit_substate_controller.sv
// MBINIT sequencer: walks CAL..REPAIRMB one wrapper at a time, arbitrates the
// single sideband TX channel, and raises end/error status toward the LTSM.
module mbinit_substate_controller #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 14
) (
  input logic CLK,
  input logic rst,
  mbinit_substate_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CAL        = 3'd1,
    ST_REPAIRCLK  = 3'd2,
    ST_REPAIRVAL  = 3'd3,
    ST_REVERSALMB = 3'd4,
    ST_REPAIRMB   = 3'd5,
    ST_DONE       = 3'd6,
    ST_ERROR      = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [4:0] sub_onehot(input state_t st);
    logic [4:0] oh;
    case (st)
      ST_CAL:        oh = 5'b00001;
      ST_REPAIRCLK:  oh = 5'b00010;
      ST_REPAIRVAL:  oh = 5'b00100;
      ST_REVERSALMB: oh = 5'b01000;
      ST_REPAIRMB:   oh = 5'b10000;
      default:       oh = 5'b00000;
    endcase
    return oh;
  endfunction

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             inflight_r;
  logic [4:0]       sub_en_r;
  logic [3:0]       tx_msg_r;
  logic             tx_valid_r;
  logic             mbinit_end_r;
  logic             train_err_r;

  logic [4:0]       onehot_s;
  logic             sub_end_s;
  logic             sub_err_s;
  logic             fwd_valid_s;
  logic [3:0]       fwd_msg_s;

  // Next-state decision and selection of the active wrapper's sideband message
  always_comb begin
    next_state_s = state_r;
    onehot_s     = sub_onehot(state_r);
    sub_end_s    = |(bus.i_sub_end & onehot_s);
    sub_err_s    = |(bus.i_sub_error & onehot_s);
    fwd_msg_s    = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      fwd_msg_s = fwd_msg_s | ({4{onehot_s[k]}} & bus.i_sub_tx_msg[4*k +: 4]);
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.i_MBINIT_start) next_state_s = ST_CAL;
        else                    next_state_s = ST_IDLE;
      end
      ST_CAL, ST_REPAIRCLK, ST_REPAIRVAL, ST_REVERSALMB, ST_REPAIRMB: begin
        if (!bus.i_MBINIT_start)            next_state_s = ST_IDLE;
        else if (sub_err_s)                 next_state_s = ST_ERROR;
        else if (sub_end_s && !inflight_r)  next_state_s = state_t'(state_r + 3'd1);
        else if (cnt_r >= CNT_LAST)         next_state_s = ST_ERROR;
        else                                next_state_s = state_r;
      end
      ST_DONE, ST_ERROR: begin
        if (!bus.i_MBINIT_start) next_state_s = ST_IDLE;
        else                     next_state_s = state_r;
      end
      default: next_state_s = ST_IDLE;
    endcase

    // A message racing the error transition is suppressed so nothing leaks in ERROR
    fwd_valid_s = (|(bus.i_sub_tx_valid & onehot_s)) && (next_state_s != ST_ERROR);
  end

  // State, timeout counter, in-flight flag and all registered outputs
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      inflight_r   <= 1'b0;
      sub_en_r     <= 5'b00000;
      tx_msg_r     <= 4'b0000;
      tx_valid_r   <= 1'b0;
      mbinit_end_r <= 1'b0;
      train_err_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r)          cnt_r <= {CNT_W{1'b0}};
      else if ((|onehot_s) && cnt_r != CNT_MAX) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                                  cnt_r <= cnt_r;
      if (tx_valid_r)                   inflight_r <= 1'b1;
      else if (bus.i_falling_edge_busy) inflight_r <= 1'b0;
      else                              inflight_r <= inflight_r;
      sub_en_r     <= sub_onehot(next_state_s);
      tx_valid_r   <= fwd_valid_s;
      tx_msg_r     <= fwd_valid_s ? fwd_msg_s : 4'b0000;
      mbinit_end_r <= (next_state_s == ST_DONE);
      train_err_r  <= (next_state_s == ST_ERROR);
    end
  end

  assign bus.o_sub_en          = sub_en_r;
  assign bus.o_TX_SbMessage    = tx_msg_r;
  assign bus.o_ValidOutDatat   = tx_valid_r;
  assign bus.o_MBINIT_end      = mbinit_end_r;
  assign bus.o_train_error_req = train_err_r;
  assign bus.o_state           = state_r;

endmodule

// File: tb/tb_mbinit_substate_controller.sv
// Directed bench for mbinit_substate_controller: a vector table plus
// hand-written sequences for walk, end-hold, timeout, abort and reset.
module tb_mbinit_substate_controller;
  localparam int TO = 20;

  logic CLK = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mbinit_substate_controller_if bus ();

  mbinit_substate_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(14)) u_dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic [4:0]  sub_end;
    logic [4:0]  sub_err;
    logic [4:0]  tx_valid;
    logic [19:0] msg;
    logic        busy;
    logic [2:0]  e_state;
    logic [4:0]  e_en;
    logic        e_valid;
    logic [3:0]  e_msg;
    logic        e_end;
    logic        e_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    bus.i_MBINIT_start      = 1'b0;
    bus.i_sub_end           = 5'b00000;
    bus.i_sub_error         = 5'b00000;
    bus.i_sub_tx_valid      = 5'b00000;
    bus.i_sub_tx_msg        = 20'h00000;
    bus.i_falling_edge_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
  endtask

  task automatic goto_sub(input int n);
    do_reset();
    bus.i_MBINIT_start = 1'b1;
    step();
    for (int k = 0; k < n - 1; k++) begin
      bus.i_sub_end = 5'(1 << k);
      step();
      bus.i_sub_end = 5'b00000;
    end
    chk($sformatf("goto_state_%0d", n), 32'(bus.o_state), 32'(n));
  endtask

  initial begin
    //           start end       err       txv       msg       busy  st    en        v     m      end   err
    tbl[0]  = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 20'h00000, 1'b0, 3'd1, 5'b00001, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'b00000, 5'b00000, 5'b00011, 20'h000A5, 1'b0, 3'd1, 5'b00001, 1'b1, 4'h5, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 20'h00000, 1'b0, 3'd1, 5'b00001, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'b00001, 5'b00000, 5'b00000, 20'h00000, 1'b0, 3'd1, 5'b00001, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'b00001, 5'b00000, 5'b00000, 20'h00000, 1'b1, 3'd1, 5'b00001, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'b00001, 5'b00000, 5'b00000, 20'h00000, 1'b0, 3'd2, 5'b00010, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'b00001, 5'b00001, 5'b00000, 20'h00000, 1'b0, 3'd2, 5'b00010, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 5'b00000, 5'b00000, 5'b00001, 20'h00005, 1'b0, 3'd2, 5'b00010, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'b00010, 5'b00010, 5'b00000, 20'h00000, 1'b0, 3'd7, 5'b00000, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 20'h00000, 1'b0, 3'd7, 5'b00000, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 20'h00000, 1'b0, 3'd0, 5'b00000, 1'b0, 4'h0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_en", 32'(bus.o_sub_en), 32'd0);
    chk("rst_valid", 32'(bus.o_ValidOutDatat), 32'd0);
    chk("rst_msg", 32'(bus.o_TX_SbMessage), 32'd0);
    chk("rst_end", 32'(bus.o_MBINIT_end), 32'd0);
    chk("rst_err", 32'(bus.o_train_error_req), 32'd0);

    // Vector table: TX gating, end-hold, inactive bits ignored, error priority
    for (int i = 0; i < 11; i++) begin
      bus.i_MBINIT_start      = tbl[i].start;
      bus.i_sub_end           = tbl[i].sub_end;
      bus.i_sub_error         = tbl[i].sub_err;
      bus.i_sub_tx_valid      = tbl[i].tx_valid;
      bus.i_sub_tx_msg        = tbl[i].msg;
      bus.i_falling_edge_busy = tbl[i].busy;
      step();
      chk($sformatf("vec%0d_state", i), 32'(bus.o_state), 32'(tbl[i].e_state));
      chk($sformatf("vec%0d_en", i), 32'(bus.o_sub_en), 32'(tbl[i].e_en));
      chk($sformatf("vec%0d_valid", i), 32'(bus.o_ValidOutDatat), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_msg", i), 32'(bus.o_TX_SbMessage), 32'(tbl[i].e_msg));
      chk($sformatf("vec%0d_end", i), 32'(bus.o_MBINIT_end), 32'(tbl[i].e_end));
      chk($sformatf("vec%0d_err", i), 32'(bus.o_train_error_req), 32'(tbl[i].e_err));
    end

    // Nominal walk: each end arrives 10 cycles after its enable
    do_reset();
    bus.i_MBINIT_start = 1'b1;
    step();
    chk("walk_en0", 32'(bus.o_sub_en), 32'h01);
    for (int k = 0; k < 5; k++) begin
      repeat (9) step();
      bus.i_sub_end = 5'(1 << k);
      step();
      bus.i_sub_end = 5'b00000;
      chk($sformatf("walk_en_after%0d", k), 32'(bus.o_sub_en), (k < 4) ? 32'(1 << (k + 1)) : 32'd0);
    end
    chk("walk_done_state", 32'(bus.o_state), 32'd6);
    chk("walk_done_end", 32'(bus.o_MBINIT_end), 32'd1);
    repeat (2) step();
    chk("walk_done_held", 32'(bus.o_MBINIT_end), 32'd1);
    bus.i_MBINIT_start = 1'b0;
    step();
    chk("walk_exit_state", 32'(bus.o_state), 32'd0);
    chk("walk_exit_end", 32'(bus.o_MBINIT_end), 32'd0);

    // End held by an in-flight message until busy falls 4 cycles later
    goto_sub(1);
    bus.i_sub_tx_valid = 5'b00001;
    bus.i_sub_tx_msg   = 20'h00003;
    step();
    chk("hold_valid", 32'(bus.o_ValidOutDatat), 32'd1);
    chk("hold_msg", 32'(bus.o_TX_SbMessage), 32'h3);
    bus.i_sub_tx_valid = 5'b00000;
    step();
    bus.i_sub_end = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold_state_%0d", i), 32'(bus.o_state), 32'd1);
    end
    bus.i_falling_edge_busy = 1'b1;
    step();
    chk("hold_busy_edge", 32'(bus.o_state), 32'd1);
    bus.i_falling_edge_busy = 1'b0;
    step();
    chk("hold_release", 32'(bus.o_state), 32'd2);
    bus.i_sub_end = 5'b00000;

    // Timeout in REPAIRVAL: ERROR exactly TO cycles after entry
    goto_sub(3);
    for (int i = 1; i < TO; i++) begin
      step();
      if (i == TO - 1) chk("to_before", 32'(bus.o_state), 32'd3);
    end
    step();
    chk("to_state", 32'(bus.o_state), 32'd7);
    chk("to_err", 32'(bus.o_train_error_req), 32'd1);
    chk("to_en", 32'(bus.o_sub_en), 32'd0);

    // Abort in REVERSALMB
    goto_sub(4);
    bus.i_MBINIT_start = 1'b0;
    step();
    chk("abort_state", 32'(bus.o_state), 32'd0);
    chk("abort_err", 32'(bus.o_train_error_req), 32'd0);
    chk("abort_en", 32'(bus.o_sub_en), 32'd0);

    // Asynchronous reset mid-REPAIRMB with a message valid
    goto_sub(5);
    bus.i_sub_tx_valid = 5'b10000;
    bus.i_sub_tx_msg   = 20'h70000;
    step();
    chk("pre_rst_valid", 32'(bus.o_ValidOutDatat), 32'd1);
    chk("pre_rst_msg", 32'(bus.o_TX_SbMessage), 32'h7);
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(bus.o_state), 32'd0);
    chk("async_rst_en", 32'(bus.o_sub_en), 32'd0);
    chk("async_rst_valid", 32'(bus.o_ValidOutDatat), 32'd0);
    chk("async_rst_msg", 32'(bus.o_TX_SbMessage), 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    clear_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
